// File: rtl/ms_latch_sequencer.sv
// Two-requester round-robin arbiter that walks a master/slave latch bank through
// master-open, dead time, slave-open, dead time, then pulses the winner's grant.
module ms_latch_sequencer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned OPEN_CYC = 2,
    parameter int unsigned GAP_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] lat_d,
    output logic             men,
    output logic             sen,
    output logic             busy,
    output logic             owner
);

    localparam int unsigned MaxCyc = (OPEN_CYC > GAP_CYC) ? OPEN_CYC : GAP_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
    localparam logic [CntW-1:0] OpenLd = CntW'(OPEN_CYC - 1);
    localparam logic [CntW-1:0] GapLd  = CntW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StMopen,
        StGap1,
        StSopen,
        StGap2,
        StDone
    } state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            ptr;
    logic            win;
    logic            cnt_zero;

    // Contention goes to the pointer; otherwise whichever single requester is high.
    assign win      = (req0 && req1) ? ptr : req1;
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= StIdle;
            cnt   <= '0;
            ptr   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            lat_d <= '0;
            men   <= 1'b0;
            sen   <= 1'b0;
            busy  <= 1'b0;
            owner <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        lat_d <= win ? din1 : din0;
                        owner <= win;
                        ptr   <= ~win;
                        busy  <= 1'b1;
                        men   <= 1'b1;
                        cnt   <= OpenLd;
                        state <= StMopen;
                    end
                end
                StMopen: begin
                    if (cnt_zero) begin
                        men   <= 1'b0;
                        cnt   <= GapLd;
                        state <= StGap1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StGap1: begin
                    if (cnt_zero) begin
                        sen   <= 1'b1;
                        cnt   <= OpenLd;
                        state <= StSopen;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StSopen: begin
                    if (cnt_zero) begin
                        sen   <= 1'b0;
                        cnt   <= GapLd;
                        state <= StGap2;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StGap2: begin
                    if (cnt_zero) begin
                        gnt0  <= ~owner;
                        gnt1  <= owner;
                        state <= StDone;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                StDone: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
